// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit multi-cycle CPU controller:
// opcodes, FSM states, datapath widths and instruction field positions.
package cpu_pkg;

    localparam int DATA_W     = 4;
    localparam int PC_W       = 4;
    localparam int REG_ADDR_W = 3;
    localparam int INSTR_W    = 16;
    localparam int NUM_REGS   = 8;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RA_MSB  = 12;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 7;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_BEQ  = 3'b100,
        OP_OUT  = 3'b101,
        OP_RSV  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [REG_ADDR_W-1:0] ra;
        logic [REG_ADDR_W-1:0] rb;
        logic [DATA_W-1:0]     imm;
    } instr_t;

    function automatic logic writes_reg(input op_e op);
        return op inside {OP_LDI, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Bus bundle between the controller and its instruction ROM, external ALU
// and output port. The controller side is the master.
interface cpu_controller_if;
    import cpu_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [DATA_W-1:0]  alu_src1;
    logic [DATA_W-1:0]  alu_src2;
    logic               alu_op;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_eq;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;

    modport master (
        output imem_addr, alu_src1, alu_src2, alu_op, out_data, out_valid,
        input  imem_data, alu_out, alu_eq
    );

    modport slave (
        input  imem_addr, alu_src1, alu_src2, alu_op, out_data, out_valid,
        output imem_data, alu_out, alu_eq
    );

endinterface

// File: rtl/reg_file.sv
// 8 x 4-bit register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear of every register.
module reg_file
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0]     rd_data1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0]     rd_data2,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] q_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_reg <= '0;
            end else if (wr_en && wr_addr == REG_ADDR_W'(gi)) begin
                q_reg <= wr_data;
            end
        end

        assign regs[gi] = q_reg;
    end

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/cpu_controller.sv
// Four-cycle-per-instruction controller (FETCH/DECODE/EXECUTE/WRITEBACK)
// driving a synchronous instruction ROM and an external ALU.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    cpu_controller_if.master  bus,
    output logic              busy,
    output logic              halted
);

    state_e            state_reg;
    logic [PC_W-1:0]   pc_reg;
    instr_t            ir_reg;
    logic [DATA_W-1:0] alu_res_reg;
    logic              alu_eq_reg;
    logic [DATA_W-1:0] alu_src1_reg;
    logic [DATA_W-1:0] alu_src2_reg;
    logic              alu_op_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic              halted_reg;

    instr_t                fetch_instr;
    logic [REG_ADDR_W-1:0] rd_addr1;
    logic [REG_ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0]     rd_data1;
    logic [DATA_W-1:0]     rd_data2;
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;

    assign fetch_instr = '{
        op:  op_e'(bus.imem_data[OP_MSB:OP_LSB]),
        ra:  bus.imem_data[RA_MSB:RA_LSB],
        rb:  bus.imem_data[RB_MSB:RB_LSB],
        imm: bus.imem_data[IMM_MSB:IMM_LSB]
    };

    // In DECODE the operands are read straight from the ROM word so the
    // registered ALU operands are already valid throughout EXECUTE.
    assign rd_addr1 = (state_reg == ST_DECODE) ? fetch_instr.ra : ir_reg.ra;
    assign rd_addr2 = (state_reg == ST_DECODE) ? fetch_instr.rb : ir_reg.rb;

    assign wr_en   = (state_reg == ST_WRITEBACK) && writes_reg(ir_reg.op);
    assign wr_data = (ir_reg.op == OP_LDI) ? ir_reg.imm : alu_res_reg;

    reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2),
        .wr_en    (wr_en),
        .wr_addr  (ir_reg.ra),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            ir_reg        <= '0;
            alu_res_reg   <= '0;
            alu_eq_reg    <= 1'b0;
            alu_src1_reg  <= '0;
            alu_src2_reg  <= '0;
            alu_op_reg    <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            // ALU drive and the output strobe are single-cycle by default
            alu_src1_reg  <= '0;
            alu_src2_reg  <= '0;
            alu_op_reg    <= 1'b0;
            out_valid_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_reg  <= ST_FETCH;
                        pc_reg     <= '0;
                        busy_reg   <= 1'b1;
                        halted_reg <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    state_reg    <= ST_EXECUTE;
                    ir_reg       <= fetch_instr;
                    alu_src1_reg <= rd_data1;
                    alu_src2_reg <= rd_data2;
                    alu_op_reg   <= (fetch_instr.op == OP_ADD);
                end
                ST_EXECUTE: begin
                    state_reg   <= ST_WRITEBACK;
                    alu_res_reg <= bus.alu_out;
                    alu_eq_reg  <= bus.alu_eq;
                    if (ir_reg.op == OP_OUT) begin
                        out_data_reg  <= rd_data1;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    if (ir_reg.op == OP_HALT) begin
                        state_reg  <= ST_HALT;
                        busy_reg   <= 1'b0;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_FETCH;
                        if (ir_reg.op == OP_BEQ && alu_eq_reg) begin
                            pc_reg <= ir_reg.imm;
                        end else begin
                            pc_reg <= pc_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr = pc_reg;
    assign bus.alu_src1  = alu_src1_reg;
    assign bus.alu_src2  = alu_src2_reg;
    assign bus.alu_op    = alu_op_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign busy          = busy_reg;
    assign halted        = halted_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: synchronous ROM and ALU models, directed
// program scenarios and random programs checked against an ISA-level model.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic halted;

    int checks = 0;
    int errors = 0;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [16];

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    assign bus.alu_out = bus.alu_op ? bus.alu_src1 + bus.alu_src2 : bus.alu_src1 - bus.alu_src2;
    assign bus.alu_eq  = (bus.alu_src1 == bus.alu_src2);

    // Per-cycle observations; cycle 1 is the first cycle after start is taken
    logic       obs_valid  [256];
    logic [3:0] obs_data   [256];
    logic       obs_busy   [256];
    logic       obs_halted [256];
    logic [3:0] obs_addr   [256];
    logic [8:0] obs_alu    [256];

    // Model expectations over the same cycle numbering
    logic       exp_valid  [256];
    logic [3:0] exp_data   [256];
    logic       exp_busy   [256];
    logic       exp_halted [256];
    logic       exp_fetch  [256];
    logic [3:0] exp_addr   [256];
    logic [8:0] exp_alu    [256];

    logic [3:0] m_regs [8];
    logic [3:0] m_out;

    function automatic logic [15:0] enc(input int op, input int ra, input int rb, input int imm);
        logic [15:0] w;
        w        = '0;
        w[15:13] = op[2:0];
        w[12:10] = ra[2:0];
        w[9:7]   = rb[2:0];
        w[3:0]   = imm[3:0];
        return w;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_out = '0;
    endtask

    task automatic sample(input int c);
        obs_valid[c]  = bus.out_valid;
        obs_data[c]   = bus.out_data;
        obs_busy[c]   = busy;
        obs_halted[c] = halted;
        obs_addr[c]   = bus.imem_addr;
        obs_alu[c]    = {bus.alu_src1, bus.alu_src2, bus.alu_op};
    endtask

    task automatic run_cycles(input int n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sample(1);
        for (int c = 2; c <= n; c++) begin
            @(posedge clk);
            #1;
            sample(c);
        end
    endtask

    // Architectural model: each instruction occupies 4 cycles, its effects
    // become visible in the last of them; HALT leaves the PC in place.
    task automatic model_run(input int n);
        logic [3:0] pc;
        logic [3:0] imm;
        logic [15:0] w;
        bit hlt;
        int c, op, ra, rb;
        pc  = '0;
        hlt = 0;
        c   = 1;
        while (c <= n) begin
            if (hlt) begin
                exp_busy[c] = 0; exp_halted[c] = 1; exp_valid[c] = 0;
                exp_data[c] = m_out; exp_fetch[c] = 0; exp_alu[c] = '0;
                c++;
            end else begin
                w   = rom[pc];
                op  = int'(w[15:13]);
                ra  = int'(w[12:10]);
                rb  = int'(w[9:7]);
                imm = w[3:0];
                for (int j = 0; j < 4; j++) begin
                    exp_busy[c+j] = 1; exp_halted[c+j] = 0; exp_valid[c+j] = 0;
                    exp_data[c+j] = m_out; exp_fetch[c+j] = (j == 0);
                    exp_addr[c+j] = pc; exp_alu[c+j] = '0;
                end
                exp_alu[c+2] = {m_regs[ra], m_regs[rb], op == 2};
                if (op == 7) hlt = 1;
                else if (op == 4 && m_regs[ra] == m_regs[rb]) pc = imm;
                else pc = pc + 4'd1;
                case (op)
                    1: m_regs[ra] = imm;
                    2: m_regs[ra] = m_regs[ra] + m_regs[rb];
                    3: m_regs[ra] = m_regs[ra] - m_regs[rb];
                    5: begin
                        m_out = m_regs[ra];
                        exp_valid[c+3] = 1;
                        exp_data[c+3]  = m_out;
                    end
                    default: ;
                endcase
                c += 4;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({busy, halted, bus.out_valid, bus.out_data, bus.imem_addr} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b halted=%b valid=%b data=%h addr=%h, expected all 0",
                     busy, halted, bus.out_valid, bus.out_data, bus.imem_addr);
        end
        checks++;
        if ({bus.alu_src1, bus.alu_src2, bus.alu_op} !== 9'd0) begin
            errors++;
            $display("FAIL reset_alu: got %h expected 0", {bus.alu_src1, bus.alu_src2, bus.alu_op});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.imem_addr !== 4'h0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b addr=%h expected busy=0 addr=0", busy, bus.imem_addr);
        end
        $display("test_reset: done");
    endtask

    task automatic test_add_out();
        int nvalid = 0;
        clear_rom();
        rom[0] = enc(1, 1, 0, 5);
        rom[1] = enc(1, 2, 0, 3);
        rom[2] = enc(2, 1, 2, 0);
        rom[3] = enc(5, 1, 0, 0);
        rom[4] = enc(7, 0, 0, 0);
        run_cycles(22);
        for (int c = 1; c <= 22; c++) if (obs_valid[c] === 1'b1) nvalid++;
        checks++;
        if (obs_valid[16] !== 1'b1 || obs_data[16] !== 4'h8) begin
            errors++;
            $display("FAIL add_out: cycle16 got valid=%b data=%h expected valid=1 data=8", obs_valid[16], obs_data[16]);
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL add_out_pulses: got %0d strobes expected 1", nvalid);
        end
        checks++;
        if (obs_halted[20] !== 1'b0 || obs_halted[21] !== 1'b1 || obs_busy[21] !== 1'b0) begin
            errors++;
            $display("FAIL add_halt: got halted20=%b halted21=%b busy21=%b expected 0 1 0",
                     obs_halted[20], obs_halted[21], obs_busy[21]);
        end
        checks++;
        if (obs_addr[22] !== 4'h4 || obs_data[22] !== 4'h8) begin
            errors++;
            $display("FAIL add_hold: got addr=%h data=%h expected addr=4 data=8", obs_addr[22], obs_data[22]);
        end
        m_regs[1] = 4'h8;
        m_regs[2] = 4'h3;
        m_out     = 4'h8;
        $display("test_add_out: out_data=%h halted=%b", obs_data[16], obs_halted[21]);
    endtask

    task automatic test_restart();
        clear_rom();
        rom[0] = enc(5, 1, 0, 0);
        rom[1] = enc(5, 2, 0, 0);
        rom[2] = enc(7, 0, 0, 0);
        run_cycles(14);
        checks++;
        if (obs_addr[1] !== 4'h0 || obs_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL restart_pc: got addr=%h busy=%b expected addr=0 busy=1", obs_addr[1], obs_busy[1]);
        end
        checks++;
        if (obs_valid[4] !== 1'b1 || obs_data[4] !== 4'h8 || obs_valid[8] !== 1'b1 || obs_data[8] !== 4'h3) begin
            errors++;
            $display("FAIL restart_regs: got %b/%h %b/%h expected 1/8 1/3",
                     obs_valid[4], obs_data[4], obs_valid[8], obs_data[8]);
        end
        checks++;
        if (obs_halted[13] !== 1'b1) begin
            errors++;
            $display("FAIL restart_halt: got %b expected 1", obs_halted[13]);
        end
        $display("test_restart: R1=%h R2=%h", obs_data[4], obs_data[8]);
    endtask

    task automatic test_sub_wrap();
        apply_reset();
        clear_rom();
        rom[0] = enc(1, 1, 0, 2);
        rom[1] = enc(1, 2, 0, 3);
        rom[2] = enc(3, 1, 2, 0);
        rom[3] = enc(5, 1, 0, 0);
        rom[4] = enc(7, 0, 0, 0);
        run_cycles(16);
        checks++;
        if (obs_valid[16] !== 1'b1 || obs_data[16] !== 4'hF) begin
            errors++;
            $display("FAIL sub_wrap: got valid=%b data=%h expected valid=1 data=f", obs_valid[16], obs_data[16]);
        end
        checks++;
        if (obs_alu[11] !== {4'h2, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL sub_alu_drive: got %h expected %h", obs_alu[11], {4'h2, 4'h3, 1'b0});
        end
        $display("test_sub_wrap: out_data=%h", obs_data[16]);
    endtask

    task automatic test_beq();
        logic [3:0] want;
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            clear_rom();
            rom[0] = enc(1, 1, 0, 7);
            rom[1] = enc(1, 2, 0, (v == 0) ? 7 : 8);
            rom[2] = enc(4, 1, 2, 6);
            rom[6] = enc(7, 0, 0, 0);
            want   = (v == 0) ? 4'h6 : 4'h3;
            run_cycles(13);
            checks++;
            if (obs_addr[13] !== want) begin
                errors++;
                $display("FAIL beq_target_%0d: got addr=%h expected %h", v, obs_addr[13], want);
            end
            $display("test_beq: variant %0d next imem_addr=%h", v, obs_addr[13]);
        end
    endtask

    task automatic test_nop_wrap();
        apply_reset();
        clear_rom();
        run_cycles(70);
        checks++;
        if (obs_addr[61] !== 4'hF || obs_addr[65] !== 4'h0) begin
            errors++;
            $display("FAIL nop_wrap: got addr61=%h addr65=%h expected f 0", obs_addr[61], obs_addr[65]);
        end
        for (int c = 1; c <= 70; c++) begin
            checks++;
            if (obs_busy[c] !== 1'b1 || obs_halted[c] !== 1'b0) begin
                errors++;
                $display("FAIL nop_busy: cycle %0d got busy=%b halted=%b expected 1 0", c, obs_busy[c], obs_halted[c]);
            end
        end
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (bus.imem_addr !== 4'h2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: got addr=%h busy=%b expected addr=2 busy=1", bus.imem_addr, busy);
        end
        $display("test_nop_wrap: addr after wrap=%h", obs_addr[65]);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        clear_rom();
        rom[0] = enc(1, 1, 0, 5);
        rom[1] = enc(1, 2, 0, 3);
        rom[2] = enc(2, 1, 2, 0);
        rom[3] = enc(5, 1, 0, 0);
        rom[4] = enc(7, 0, 0, 0);
        run_cycles(10);
        @(posedge clk);
        #1;
        checks++;
        if ({bus.alu_src1, bus.alu_src2, bus.alu_op} !== {4'h5, 4'h3, 1'b1}) begin
            errors++;
            $display("FAIL add_alu_drive: got %h expected %h",
                     {bus.alu_src1, bus.alu_src2, bus.alu_op}, {4'h5, 4'h3, 1'b1});
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({busy, halted, bus.out_valid, bus.out_data, bus.imem_addr, bus.alu_src1, bus.alu_src2, bus.alu_op} !== 20'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b halted=%b valid=%b data=%h addr=%h alu=%h expected all 0",
                     busy, halted, bus.out_valid, bus.out_data, bus.imem_addr,
                     {bus.alu_src1, bus.alu_src2, bus.alu_op});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.imem_addr !== 4'h0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got busy=%b addr=%h valid=%b expected 0 0 0", busy, bus.imem_addr, bus.out_valid);
        end
        clear_rom();
        rom[0] = enc(5, 1, 0, 0);
        rom[1] = enc(7, 0, 0, 0);
        run_cycles(6);
        checks++;
        if (obs_valid[4] !== 1'b1 || obs_data[4] !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_r1: got valid=%b data=%h expected valid=1 data=0", obs_valid[4], obs_data[4]);
        end
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_out = '0;
        $display("test_reset_mid: R1 after reset=%h", obs_data[4]);
    endtask

    task automatic test_random();
        int op;
        int nout;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            for (int i = 0; i < 16; i++) begin
                op = int'($urandom_range(0, 7));
                if (op == 7 && $urandom_range(0, 2) != 0) op = 5;
                rom[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            end
            model_run(160);
            run_cycles(160);
            nout = 0;
            for (int c = 1; c <= 160; c++) begin
                if (exp_valid[c]) nout++;
                checks++;
                if (obs_valid[c] !== exp_valid[c] || obs_data[c] !== exp_data[c]) begin
                    errors++;
                    $display("FAIL rand_out it%0d c%0d: got valid=%b data=%h expected valid=%b data=%h",
                             it, c, obs_valid[c], obs_data[c], exp_valid[c], exp_data[c]);
                end
                checks++;
                if (obs_busy[c] !== exp_busy[c] || obs_halted[c] !== exp_halted[c]) begin
                    errors++;
                    $display("FAIL rand_status it%0d c%0d: got busy=%b halted=%b expected busy=%b halted=%b",
                             it, c, obs_busy[c], obs_halted[c], exp_busy[c], exp_halted[c]);
                end
                checks++;
                if (obs_alu[c] !== exp_alu[c]) begin
                    errors++;
                    $display("FAIL rand_alu it%0d c%0d: got %h expected %h", it, c, obs_alu[c], exp_alu[c]);
                end
                if (exp_fetch[c]) begin
                    checks++;
                    if (obs_addr[c] !== exp_addr[c]) begin
                        errors++;
                        $display("FAIL rand_pc it%0d c%0d: got %h expected %h", it, c, obs_addr[c], exp_addr[c]);
                    end
                end
            end
            $display("test_random: program %0d, %0d outputs expected, halted=%b", it, nout, exp_halted[160]);
        end
    endtask

    initial begin
        clear_rom();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_out = '0;
        test_reset();
        test_add_out();
        test_restart();
        test_sub_wrap();
        test_beq();
        test_nop_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
